// File: rtl/branch_prediction_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_prediction_unit
//  Description : Direct-mapped BTB with 2-bit counters, I->R->C prediction
//                tracking, C-stage training and prediction statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module branch_prediction_unit #(
    parameter int XLEN    = `BIT_COUNT,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_I,
    output logic            Predict,
    output logic [XLEN-1:0] Prediction,
    input  logic            StallIR,
    input  logic            StallRC,
    input  logic            FlushIR,
    input  logic            FlushRC,
    input  logic            Jump_R,
    input  logic [XLEN-1:0] PCpImm_R,
    output logic            PredictionCorrect_R,
    input  logic            ResolveValid_C,
    input  logic            ResolvedTaken_C,
    input  logic [XLEN-1:0] ResolvedTarget_C,
    output logic            PredictionCorrect_C,
    output logic [31:0]     PredCount,
    output logic [31:0]     MispredCount
);

    localparam int c_TAG_W = XLEN - IDX_W - 2;

    logic               r_valid  [ENTRIES];
    logic [c_TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:1]    r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic            r_pred_taken_r, r_pred_taken_c;
    logic [XLEN-1:0] r_pred_target_r, r_pred_target_c;
    logic [XLEN-1:0] r_pc_r, r_pc_c;
    logic [31:0]     r_pred_count, r_mispred_count;

    logic [IDX_W-1:0]   w_idx_i, w_idx_c;
    logic [c_TAG_W-1:0] w_tag_c;
    logic               w_hit_i, w_hit_c;
    logic               w_unused_bits;

    // Lookup sees the pre-training contents when I and C share an index.
    assign w_idx_i    = PC_I[IDX_W+1:2];
    assign w_hit_i    = r_valid[w_idx_i] && (r_tag[w_idx_i] == PC_I[XLEN-1:IDX_W+2]);
    assign Predict    = w_hit_i && r_ctr[w_idx_i][1];
    assign Prediction = Predict ? {r_target[w_idx_i], 1'b0} : '0;

    assign w_idx_c = r_pc_c[IDX_W+1:2];
    assign w_tag_c = r_pc_c[XLEN-1:IDX_W+2];
    assign w_hit_c = r_valid[w_idx_c] && (r_tag[w_idx_c] == w_tag_c);

    assign PredictionCorrect_R = r_pred_taken_r && Jump_R &&
                                 (r_pred_target_r == {PCpImm_R[XLEN-1:1], 1'b0});

    always_comb begin
        PredictionCorrect_C = 1'b0;
        if (ResolveValid_C) begin
            if (ResolvedTaken_C)
                PredictionCorrect_C = r_pred_taken_c &&
                    (r_pred_target_c == {ResolvedTarget_C[XLEN-1:1], 1'b0});
            else
                PredictionCorrect_C = !r_pred_taken_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (ResolveValid_C) begin
            if (w_hit_c) begin
                if (ResolvedTaken_C) begin
                    if (r_ctr[w_idx_c] != 2'b11)
                        r_ctr[w_idx_c] <= r_ctr[w_idx_c] + 2'b01;
                    r_target[w_idx_c] <= ResolvedTarget_C[XLEN-1:1];
                end else if (r_ctr[w_idx_c] != 2'b00) begin
                    r_ctr[w_idx_c] <= r_ctr[w_idx_c] - 2'b01;
                end
            end else if (ResolvedTaken_C) begin
                r_valid[w_idx_c]  <= 1'b1;
                r_tag[w_idx_c]    <= w_tag_c;
                r_target[w_idx_c] <= ResolvedTarget_C[XLEN-1:1];
                r_ctr[w_idx_c]    <= 2'b10;
            end
        end
    end

    // A flush only kills the prediction flag; target/PC may be left stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred_taken_r  <= 1'b0;
            r_pred_target_r <= '0;
            r_pc_r          <= '0;
        end else if (FlushIR) begin
            r_pred_taken_r  <= 1'b0;
        end else if (!StallIR) begin
            r_pred_taken_r  <= Predict;
            r_pred_target_r <= Prediction;
            r_pc_r          <= PC_I;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred_taken_c  <= 1'b0;
            r_pred_target_c <= '0;
            r_pc_c          <= '0;
        end else if (FlushRC) begin
            r_pred_taken_c  <= 1'b0;
        end else if (!StallRC) begin
            r_pred_taken_c  <= r_pred_taken_r;
            r_pred_target_c <= r_pred_target_r;
            r_pc_c          <= r_pc_r;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred_count    <= '0;
            r_mispred_count <= '0;
        end else if (ResolveValid_C) begin
            if (r_pred_count != 32'hFFFF_FFFF)
                r_pred_count <= r_pred_count + 32'd1;
            if (!PredictionCorrect_C && (r_mispred_count != 32'hFFFF_FFFF))
                r_mispred_count <= r_mispred_count + 32'd1;
        end
    end

    assign PredCount    = r_pred_count;
    assign MispredCount = r_mispred_count;

    // Byte-offset bits never participate in indexing or target compare.
    assign w_unused_bits = &{1'b0, PC_I[1:0], PCpImm_R[0], ResolvedTarget_C[0], r_pc_c[1:0]};

endmodule

`default_nettype wire
